wb_commit: RTL and testbench



---
 rtl/wb_commit_pkg.sv | 14 +
 rtl/wb_commit_load_ext.sv | 26 ++
 rtl/wb_commit.sv | 128 ++++++++++++
 tb/tb_wb_commit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared widths, load-size encodings and FSM state encodings for the writeback stage.
package wb_commit_pkg;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [1:0] LS_B = 2'b00;
  localparam logic [1:0] LS_H = 2'b01;
  localparam logic [1:0] LS_W = 2'b10;
  localparam logic [1:0] LS_D = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WAIT_LD = 2'b01;
  localparam logic [1:0] ST_COMMIT  = 2'b10;
endpackage

// File: rtl/wb_commit_load_ext.sv
// Load data alignment: shift the raw doubleword down by the byte offset, then
// pick the access size and sign- or zero-extend it.
module load_ext
  import wb_commit_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] shifted;

  // Logical shift, so bytes coming from above bit 63 are zero.
  assign shifted = data_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (size_i)
      LS_B:    data_o = {{(XLEN-8){~unsigned_i & shifted[7]}},   shifted[7:0]};
      LS_H:    data_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      LS_W:    data_o = {{(XLEN-32){~unsigned_i & shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end
endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: drives the register file write port and the difftest
// commit PC, waiting for the load response when the retiring instruction is a load.
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [XLEN-1:0]   mem_pc_i,
  input  logic              mem_rd_wen_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic [XLEN-1:0]   mem_alu_res_i,
  input  logic              mem_is_load_i,
  input  logic [1:0]        mem_ld_size_i,
  input  logic              mem_ld_unsigned_i,
  input  logic [2:0]        mem_addr_lo_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wr_en_o,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [XLEN-1:0]   wr_data_o,
  output logic [XLEN-1:0]   pc_wb_o
);
  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rd_wen_q, rd_wen_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [2:0]        addr_lo_q, addr_lo_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic [XLEN-1:0]   pc_wb_q, pc_wb_d;
  logic [XLEN-1:0]   ld_data;
  logic              accept;

  load_ext u_load_ext (
    .data_i     (dmem_rdata_i),
    .addr_lo_i  (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  assign mem_ready_o = (state_q != ST_WAIT_LD);
  assign accept      = mem_valid_i && mem_ready_o;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    rd_wen_d  = rd_wen_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_lo_d = addr_lo_q;
    wr_en_d   = 1'b0;
    pc_wb_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_WAIT_LD: begin
        if (dmem_rvalid_i) begin
          state_d   = ST_COMMIT;
          wr_data_d = ld_data;
          wr_addr_d = rd_q;
          wr_en_d   = rd_wen_q && (rd_q != '0);
          pc_wb_d   = pc_q;
        end
      end
      default: begin
        // IDLE and COMMIT both accept; a response arriving here is ignored.
        state_d = ST_IDLE;
        if (accept) begin
          if (mem_is_load_i) begin
            state_d   = ST_WAIT_LD;
            pc_d      = mem_pc_i;
            rd_d      = mem_rd_addr_i;
            rd_wen_d  = mem_rd_wen_i;
            size_d    = mem_ld_size_i;
            uns_d     = mem_ld_unsigned_i;
            addr_lo_d = mem_addr_lo_i;
          end else begin
            state_d   = ST_COMMIT;
            wr_data_d = mem_alu_res_i;
            wr_addr_d = mem_rd_addr_i;
            wr_en_d   = mem_rd_wen_i && (mem_rd_addr_i != '0);
            pc_wb_d   = mem_pc_i;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      size_q    <= LS_B;
      uns_q     <= 1'b0;
      addr_lo_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pc_wb_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      rd_wen_q  <= rd_wen_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_lo_q <= addr_lo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pc_wb_q   <= pc_wb_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign pc_wb_o   = pc_wb_q;
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: hand-computed expected values checked with
// immediate assertions, one line printed per transaction.
module tb_wb_commit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [63:0] mem_pc_i;
  logic        mem_rd_wen_i;
  logic [4:0]  mem_rd_addr_i;
  logic [63:0] mem_alu_res_i;
  logic        mem_is_load_i;
  logic [1:0]  mem_ld_size_i;
  logic        mem_ld_unsigned_i;
  logic [2:0]  mem_addr_lo_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic [63:0] pc_wb_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_valid_i       (mem_valid_i),
    .mem_ready_o       (mem_ready_o),
    .mem_pc_i          (mem_pc_i),
    .mem_rd_wen_i      (mem_rd_wen_i),
    .mem_rd_addr_i     (mem_rd_addr_i),
    .mem_alu_res_i     (mem_alu_res_i),
    .mem_is_load_i     (mem_is_load_i),
    .mem_ld_size_i     (mem_ld_size_i),
    .mem_ld_unsigned_i (mem_ld_unsigned_i),
    .mem_addr_lo_i     (mem_addr_lo_i),
    .dmem_rvalid_i     (dmem_rvalid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .wr_en_o           (wr_en_o),
    .wr_addr_o         (wr_addr_o),
    .wr_data_o         (wr_data_o),
    .pc_wb_o           (pc_wb_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_commit(input string tag, input logic en, input logic [4:0] addr,
                            input logic [63:0] data, input logic [63:0] pc);
    chk({tag, ".wr_en"}, {63'd0, wr_en_o}, {63'd0, en});
    if (en) chk({tag, ".wr_addr"}, {59'd0, wr_addr_o}, {59'd0, addr});
    chk({tag, ".wr_data"}, wr_data_o, data);
    chk({tag, ".pc_wb"}, pc_wb_o, pc);
    $display("txn %s: wr_en=%0b addr=%0d data=%h pc_wb=%h", tag, wr_en_o, wr_addr_o, wr_data_o, pc_wb_o);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".wr_en"}, {63'd0, wr_en_o}, 64'd0);
    chk({tag, ".pc_wb"}, pc_wb_o, 64'd0);
  endtask

  task automatic present_alu(input logic [63:0] pc, input logic wen, input logic [4:0] rd,
                             input logic [63:0] res);
    mem_valid_i = 1'b1; mem_is_load_i = 1'b0;
    mem_pc_i = pc; mem_rd_wen_i = wen; mem_rd_addr_i = rd; mem_alu_res_i = res;
  endtask

  task automatic present_load(input logic [63:0] pc, input logic [4:0] rd, input logic [1:0] size,
                              input logic uns, input logic [2:0] lo);
    mem_valid_i = 1'b1; mem_is_load_i = 1'b1;
    mem_pc_i = pc; mem_rd_wen_i = 1'b1; mem_rd_addr_i = rd;
    mem_ld_size_i = size; mem_ld_unsigned_i = uns; mem_addr_lo_i = lo;
  endtask

  // Accept a load, return the response the next cycle, land on its commit cycle.
  task automatic quick_load(input logic [63:0] pc, input logic [4:0] rd, input logic [1:0] size,
                            input logic uns, input logic [2:0] lo, input logic [63:0] rdata);
    present_load(pc, rd, size, uns, lo);
    step();
    mem_valid_i = 1'b0;
    chk("ld.ready_wait", {63'd0, mem_ready_o}, 64'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    step();
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_valid_i = 1'b0; mem_pc_i = '0; mem_rd_wen_i = 1'b0;
    mem_rd_addr_i = '0; mem_alu_res_i = '0; mem_is_load_i = 1'b0; mem_ld_size_i = 2'b00;
    mem_ld_unsigned_i = 1'b0; mem_addr_lo_i = '0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

    step(); step();
    chk_commit("reset", 1'b0, 5'd0, 64'd0, 64'd0);
    chk("reset.wr_addr", {59'd0, wr_addr_o}, 64'd0);
    chk("reset.ready", {63'd0, mem_ready_o}, 64'd1);
    rst_n = 1'b1;
    step();

    // ALU op, one-cycle latency, then idle
    present_alu(64'h8000_0000, 1'b1, 5'd5, 64'h1234);
    step();
    mem_valid_i = 1'b0;
    chk_commit("alu1", 1'b1, 5'd5, 64'h1234, 64'h8000_0000);
    step();
    chk_idle("alu1.after");

    // LB at byte 3, response 4 cycles after accept
    present_load(64'h8000_0100, 5'd7, 2'b00, 1'b0, 3'd3);
    step();
    mem_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lb.ready_wait", {63'd0, mem_ready_o}, 64'd0);
      chk_idle("lb.wait");
      step();
    end
    chk("lb.ready_wait", {63'd0, mem_ready_o}, 64'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h0000_0000_80FF_0000;
    step();
    dmem_rvalid_i = 1'b0;
    chk_commit("lb", 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 64'h8000_0100);
    chk("lb.ready_commit", {63'd0, mem_ready_o}, 64'd1);
    step();
    chk_idle("lb.after");

    // LWU then LW of the same word; the second load is accepted in the commit cycle
    quick_load(64'h8000_0200, 5'd8, 2'b10, 1'b1, 3'd4, 64'hDEAD_BEEF_0000_0000);
    chk_commit("lwu", 1'b1, 5'd8, 64'h0000_0000_DEAD_BEEF, 64'h8000_0200);
    quick_load(64'h8000_0204, 5'd9, 2'b10, 1'b0, 3'd4, 64'hDEAD_BEEF_0000_0000);
    chk_commit("lw", 1'b1, 5'd9, 64'hFFFF_FFFF_DEAD_BEEF, 64'h8000_0204);

    // Other sizes: LH at the top half, LBU at the top byte, LD, LHU
    quick_load(64'h8000_0208, 5'd10, 2'b01, 1'b0, 3'd6, 64'hF00D_0000_0000_0000);
    chk_commit("lh", 1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_F00D, 64'h8000_0208);
    quick_load(64'h8000_020C, 5'd11, 2'b00, 1'b1, 3'd7, 64'h8000_0000_0000_0000);
    chk_commit("lbu", 1'b1, 5'd11, 64'h0000_0000_0000_0080, 64'h8000_020C);
    quick_load(64'h8000_0210, 5'd12, 2'b11, 1'b0, 3'd0, 64'h8123_4567_89AB_CDEF);
    chk_commit("ld", 1'b1, 5'd12, 64'h8123_4567_89AB_CDEF, 64'h8000_0210);
    quick_load(64'h8000_0214, 5'd13, 2'b01, 1'b1, 3'd2, 64'h0000_0000_9876_0000);
    chk_commit("lhu", 1'b1, 5'd13, 64'h0000_0000_0000_9876, 64'h8000_0214);
    step();
    chk_idle("loads.after");

    // Three back-to-back ALU ops, the first to x0
    present_alu(64'h8000_0300, 1'b1, 5'd0, 64'hAAAA);
    step();
    chk_commit("b2b.x0", 1'b0, 5'd0, 64'hAAAA, 64'h8000_0300);
    chk("b2b.ready0", {63'd0, mem_ready_o}, 64'd1);
    present_alu(64'h8000_0304, 1'b1, 5'd1, 64'hBBBB);
    step();
    chk_commit("b2b.x1", 1'b1, 5'd1, 64'hBBBB, 64'h8000_0304);
    chk("b2b.ready1", {63'd0, mem_ready_o}, 64'd1);
    present_alu(64'h8000_0308, 1'b1, 5'd2, 64'hCCCC);
    step();
    mem_valid_i = 1'b0;
    chk_commit("b2b.x2", 1'b1, 5'd2, 64'hCCCC, 64'h8000_0308);
    chk("b2b.ready2", {63'd0, mem_ready_o}, 64'd1);
    step();
    chk_idle("b2b.after");

    // Reset while a load waits; the stale response must be dropped
    present_load(64'h8000_0400, 5'd14, 2'b11, 1'b0, 3'd0);
    step();
    mem_valid_i = 1'b0;
    chk("rst.ready_wait", {63'd0, mem_ready_o}, 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_commit("rst.mid", 1'b0, 5'd0, 64'd0, 64'd0);
    chk("rst.wr_addr", {59'd0, wr_addr_o}, 64'd0);
    chk("rst.ready", {63'd0, mem_ready_o}, 64'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h1111_2222_3333_4444;
    step();
    dmem_rvalid_i = 1'b0;
    chk_commit("rst.stale", 1'b0, 5'd0, 64'd0, 64'd0);
    present_alu(64'h8000_0500, 1'b1, 5'd3, 64'h5555);
    step();
    mem_valid_i = 1'b0;
    chk_commit("rst.alu", 1'b1, 5'd3, 64'h5555, 64'h8000_0500);
    step();

    // Spurious response in IDLE, then a store
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    dmem_rvalid_i = 1'b0;
    chk_commit("spurious", 1'b0, 5'd0, 64'h5555, 64'd0);
    present_alu(64'h8000_0600, 1'b0, 5'd9, 64'h7777);
    step();
    mem_valid_i = 1'b0;
    chk_commit("store", 1'b0, 5'd9, 64'h7777, 64'h8000_0600);
    step();
    chk_idle("store.after1");
    step();
    chk_idle("store.after2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
